// File: rtl/series_pkg.sv
// Shared definitions for the series-evaluation arbiter.
//   - Default operand/result widths and engine timeout.
//   - FSM state encoding used by series_arbiter.
package series_pkg;

    localparam int DW_DEF      = 8;
    localparam int RW_DEF      = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RELEASE
    } state_t;

endpackage

// File: rtl/series_arbiter_rr_picker.sv
// Round-robin priority search.
// Ports:
//   req         - per-requester request levels
//   last_winner - index of the most recently served requester
//   winner      - one-hot winner (all zero when no request is pending)
//   winner_idx  - binary index of the winner (0 when no request is pending)
// The search starts at (last_winner+1) mod N_REQ and wraps around, so the
// previous winner has the lowest priority.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last_winner,
    output logic [N_REQ-1:0] winner,
    output logic [LW-1:0]    winner_idx
);

    logic          found;
    logic [LW-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = LW'((int'(last_winner) + off) % N_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/series_arbiter.sv
// Round-robin arbiter sharing one series-evaluation engine among N_REQ
// requesters.
// Ports:
//   clk, rst            - clock and synchronous active-low reset
//   req                 - request levels, held until the matching done pulse
//   x_in, y_in          - packed operands, requester i at [i*DW +: DW]
//   grant               - one-hot owner of the engine (zero when idle)
//   done, error         - completion pulse to the owner; error marks a timeout
//   result              - last captured engine result, held between jobs
//   eng_start           - one-cycle engine start request
//   eng_x, eng_y        - operands of the current job, stable for the whole job
//   eng_ready           - engine idle flag (low while computing)
//   eng_result          - engine result, valid when eng_ready re-rises
module series_arbiter
    import series_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] x_in,
    input  logic [N_REQ*DW-1:0] y_in,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                error,
    output logic [RW-1:0]       result,
    output logic                eng_start,
    output logic [DW-1:0]       eng_x,
    output logic [DW-1:0]       eng_y,
    input  logic                eng_ready,
    input  logic [RW-1:0]       eng_result
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     last_q, last_d;
    logic [DW-1:0]     eng_x_q, eng_x_d;
    logic [DW-1:0]     eng_y_q, eng_y_d;
    logic [RW-1:0]     result_q, result_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              error_q, error_d;
    logic              eng_start_q, eng_start_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              to_q, to_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [LW-1:0]     pick_idx;
    logic [DW-1:0]     x_arr [N_REQ];
    logic [DW-1:0]     y_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign x_arr[i] = x_in[i*DW +: DW];
        assign y_arr[i] = y_in[i*DW +: DW];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .LW    (LW)
    ) u_picker (
        .req         (req),
        .last_winner (last_q),
        .winner      (pick_oh),
        .winner_idx  (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        last_d      = last_q;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        result_d    = result_q;
        done_d      = '0;
        error_d     = 1'b0;
        eng_start_d = 1'b0;
        cnt_d       = cnt_q;
        to_d        = to_q;

        case (state_q)
            IDLE: begin
                // Winner and operands are latched on the way into GRANT, so
                // requests arriving later wait for the next arbitration.
                if (|req && eng_ready) begin
                    state_d = GRANT;
                    grant_d = pick_oh;
                    idx_d   = pick_idx;
                    eng_x_d = x_arr[pick_idx];
                    eng_y_d = y_arr[pick_idx];
                end
            end
            GRANT: begin
                state_d     = START;
                eng_start_d = 1'b1;
            end
            START: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RELEASE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!eng_ready) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RELEASE;
                    to_d    = 1'b1;
                end else if (eng_ready) begin
                    state_d  = RELEASE;
                    result_d = eng_result;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                // done/error leave as registered pulses together with the
                // grant being dropped.
                state_d = IDLE;
                done_d  = grant_q;
                error_d = to_q;
                grant_d = '0;
                last_d  = idx_q;
                to_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            last_q      <= LW'(N_REQ - 1);
            eng_x_q     <= '0;
            eng_y_q     <= '0;
            result_q    <= '0;
            done_q      <= '0;
            error_q     <= 1'b0;
            eng_start_q <= 1'b0;
            cnt_q       <= '0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            eng_x_q     <= eng_x_d;
            eng_y_q     <= eng_y_d;
            result_q    <= result_d;
            done_q      <= done_d;
            error_q     <= error_d;
            eng_start_q <= eng_start_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign error     = error_q;
    assign result    = result_q;
    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;

endmodule

// File: tb/tb_series_arbiter.sv
// Directed bench for series_arbiter. A small engine stub answers eng_start by
// dropping eng_ready for 6 cycles and returning x*y*16; it can be told to
// ignore starts so the arbiter's timeout path is exercised.
module tb_series_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] x_in, y_in;
    logic [N-1:0]    grant, done;
    logic            error;
    logic [RW-1:0]   result;
    logic            eng_start;
    logic [DW-1:0]   eng_x, eng_y;
    logic            eng_ready;
    logic [RW-1:0]   eng_result;

    logic            eng_ignore;
    int              busy_cnt;
    int              n_chk  = 0;
    int              n_pass = 0;
    int              k, n, starts, dones;

    always #5 clk = ~clk;

    series_arbiter #(
        .N_REQ   (N),
        .DW      (DW),
        .RW      (RW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .x_in       (x_in),
        .y_in       (y_in),
        .grant      (grant),
        .done       (done),
        .error      (error),
        .result     (result),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_ready  (eng_ready),
        .eng_result (eng_result)
    );

    // Engine stub
    always @(posedge clk) begin
        if (!rst) begin
            eng_ready  <= 1'b1;
            busy_cnt   <= 0;
            eng_result <= '0;
        end else if (eng_start && !eng_ignore) begin
            eng_ready  <= 1'b0;
            busy_cnt   <= 6;
            eng_result <= RW'(eng_x * eng_y * 16);
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt  <= 0;
            eng_ready <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait for the next grant, check it, then wait for done and check the job.
    task automatic serve(input string tag, input logic [N-1:0] g, input logic [DW-1:0] ex,
                         input logic [RW-1:0] res, input logic drop);
        int w;
        w = 0;
        while (grant == '0 && w < 10) begin step(); w++; end
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".eng_x"}, eng_x, ex);
        w = 0;
        while (done == '0 && w < 200) begin step(); w++; end
        chk({tag, ".done"}, done, g);
        chk({tag, ".result"}, result, res);
        chk({tag, ".error"}, error, 1'b0);
        if (drop) req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        req        = '0;
        eng_ignore = 1'b0;
        x_in       = {8'h33, 8'h22, 8'h11, 8'h03};
        y_in       = {8'h04, 8'h03, 8'h02, 8'h05};
        step();
        step();
        chk("rst.grant", grant, 4'b0000);
        chk("rst.done", done, 4'b0000);
        chk("rst.error", error, 1'b0);
        chk("rst.eng_start", eng_start, 1'b0);
        chk("rst.eng_x", eng_x, 8'h00);
        chk("rst.eng_y", eng_y, 8'h00);
        chk("rst.result", result, 16'h0000);
        rst = 1'b1;
        step();

        // Single request: done 11 cycles after req with a 6-cycle engine
        req = 4'b0001;
        step();
        chk("single.grant", grant, 4'b0001);
        chk("single.eng_x", eng_x, 8'h03);
        chk("single.eng_y", eng_y, 8'h05);
        step();
        chk("single.eng_start", eng_start, 1'b1);
        starts = 0;
        dones  = 0;
        repeat (8) begin
            step();
            starts += int'(eng_start);
            dones  += int'(|done);
        end
        chk("single.extra_start", starts, 0);
        chk("single.early_done", dones, 0);
        step();
        chk("single.done", done, 4'b0001);
        chk("single.result", result, 16'h00F0);
        chk("single.error", error, 1'b0);
        chk("single.grant_clr", grant, 4'b0000);
        req = '0;
        step();
        chk("single.one_pulse", done, 4'b0000);

        // Restore requester 0 as first priority
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // All requesters active: strict rotation
        req = 4'b1111;
        serve("rr0", 4'b0001, 8'h03, 16'h00F0, 1'b0);
        serve("rr1", 4'b0010, 8'h11, 16'h0220, 1'b0);
        serve("rr2", 4'b0100, 8'h22, 16'h0660, 1'b0);
        serve("rr3", 4'b1000, 8'h33, 16'h0CC0, 1'b1);

        // Fairness: after requester 2, search wraps past 3 to 0
        req = 4'b0100;
        serve("fair_a", 4'b0100, 8'h22, 16'h0660, 1'b1);
        req = 4'b0101;
        serve("fair_b", 4'b0001, 8'h03, 16'h00F0, 1'b1);

        // Early drop of req during WAIT_DONE
        req = 4'b0010;
        k = 0;
        while (eng_ready && k < 20) begin step(); k++; end
        step();
        req = '0;
        k = 0;
        while (done == '0 && k < 50) begin step(); k++; end
        chk("drop.done", done, 4'b0010);
        chk("drop.result", result, 16'h0220);
        step();
        chk("drop.one_pulse", done, 4'b0000);

        // Timeout: engine ignores the start, done+error TO+2 cycles after START
        eng_ignore = 1'b1;
        req = 4'b1000;
        k = 0;
        while (!eng_start && k < 10) begin step(); k++; end
        chk("to.start", eng_start, 1'b1);
        n = 0;
        while (done == '0 && n < 200) begin step(); n++; end
        chk("to.latency", n, TO + 2);
        chk("to.done", done, 4'b1000);
        chk("to.error", error, 1'b1);
        chk("to.result_held", result, 16'h0220);
        req = '0;
        step();
        chk("to.error_pulse", error, 1'b0);
        eng_ignore = 1'b0;

        // Reset in the middle of a job
        req = 4'b0001;
        k = 0;
        while (eng_ready && k < 20) begin step(); k++; end
        step();
        rst = 1'b0;
        req = '0;
        step();
        chk("midrst.grant", grant, 4'b0000);
        chk("midrst.done", done, 4'b0000);
        chk("midrst.eng_start", eng_start, 1'b0);
        chk("midrst.result", result, 16'h0000);
        rst = 1'b1;
        dones = 0;
        repeat (10) begin
            step();
            dones += int'(|done);
        end
        chk("midrst.no_done", dones, 0);
        req = 4'b0010;
        serve("post_rst", 4'b0010, 8'h11, 16'h0220, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
